// File: rtl/bsg_axil_rxs.sv
// AXI4-Lite read slave draining a bank of receive FIFOs and
// exposing per-slot occupancy and interrupt status registers.

package bsg_axil_to_mcl_pkg;
    parameter int axil_base_addr_width_gp = 8;
    parameter int axil_slot_idx_width_gp  = 4;
    parameter logic [31:0] axil_m_slot_addr_gp = 32'h0000_0100;
    parameter logic [7:0] axil_mm2s_ofs_isr_gp  = 8'h00;
    parameter logic [7:0] axil_mm2s_ofs_rdfo_gp = 8'h1C;
    parameter logic [7:0] axil_mm2s_ofs_rdfd_gp = 8'h20;
endpackage

module bsg_axil_rxs
    import bsg_axil_to_mcl_pkg::*;
#(
    // Must be overridden by the instantiating design.
    parameter int num_fifos_p = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [31:0]                  araddr_i,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    output logic [31:0]                  rdata_o,
    output logic [1:0]                   rresp_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    input  logic [num_fifos_p-1:0][31:0] rxs_i,
    input  logic [num_fifos_p-1:0]       rxs_v_i,
    output logic [num_fifos_p-1:0]       rxs_yumi_o,
    input  logic [num_fifos_p-1:0][31:0] rdfo_i,
    input  logic [num_fifos_p-1:0][31:0] isr_i
);

    localparam int bw_lp = axil_base_addr_width_gp;
    localparam int sw_lp = axil_slot_idx_width_gp;
    localparam int slot_base_lp = int'(axil_m_slot_addr_gp >> bw_lp);

    typedef enum logic [1:0] {
        E_RD_IDLE   = 2'd0,
        E_RD_DECODE = 2'd1,
        E_RD_RESP   = 2'd2
    } state_e;

    state_e state_r;
    logic [31:0] rd_addr_r;
    logic [31:0] rdata_r;
    logic [1:0]  rresp_r;
    logic        arready_r;
    logic        rvalid_r;

    logic [sw_lp-1:0]       slot_f;
    logic [bw_lp-1:0]       ofs_f;
    logic [31:0]            dec_data;
    logic [1:0]             dec_resp;
    logic [num_fifos_p-1:0] dec_pop;

    assign slot_f = rd_addr_r[bw_lp +: sw_lp];
    assign ofs_f  = rd_addr_r[0 +: bw_lp];

    always_comb begin
        dec_data = '0;
        dec_resp = 2'b11;
        dec_pop  = '0;
        for (int i = 0; i < num_fifos_p; i++) begin
            if (slot_f == sw_lp'(i + slot_base_lp)) begin
                dec_resp = 2'b00;
                if (ofs_f == bw_lp'(axil_mm2s_ofs_isr_gp)) begin
                    dec_data = isr_i[i];
                end else if (ofs_f == bw_lp'(axil_mm2s_ofs_rdfo_gp)) begin
                    dec_data = rdfo_i[i];
                end else if (ofs_f == bw_lp'(axil_mm2s_ofs_rdfd_gp)) begin
                    if (rxs_v_i[i]) begin
                        dec_data   = rxs_i[i];
                        dec_pop[i] = 1'b1;
                    end else begin
                        dec_resp = 2'b10;
                    end
                end
            end
        end
    end

    // The pop must line up with the cycle the head word is captured.
    assign rxs_yumi_o = (state_r == E_RD_DECODE && !reset_i) ? dec_pop : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= E_RD_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rd_addr_r <= '0;
            rdata_r   <= '0;
            rresp_r   <= '0;
        end else begin
            unique case (state_r)
                E_RD_IDLE: begin
                    if (arvalid_i) begin
                        rd_addr_r <= araddr_i;
                        arready_r <= 1'b0;
                        state_r   <= E_RD_DECODE;
                    end
                end
                E_RD_DECODE: begin
                    rdata_r  <= dec_data;
                    rresp_r  <= dec_resp;
                    rvalid_r <= 1'b1;
                    state_r  <= E_RD_RESP;
                end
                E_RD_RESP: begin
                    if (rready_i) begin
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                        state_r   <= E_RD_IDLE;
                    end
                end
                default: begin
                    rvalid_r  <= 1'b0;
                    arready_r <= 1'b1;
                    state_r   <= E_RD_IDLE;
                end
            endcase
        end
    end

    assign arready_o = arready_r;
    assign rvalid_o  = rvalid_r;
    assign rdata_o   = rdata_r;
    assign rresp_o   = rresp_r;

endmodule

// File: tb/tb_bsg_axil_rxs.sv
// Scoreboard bench for bsg_axil_rxs with two FIFO slots.

module tb_bsg_axil_rxs;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [N-1:0][31:0] rxs = '0;
    logic [N-1:0]      rxs_v = '0;
    logic [N-1:0]      rxs_yumi;
    logic [N-1:0][31:0] rdfo = '0;
    logic [N-1:0][31:0] isr = '0;

    bsg_axil_rxs #(.num_fifos_p(N)) dut (
        .clk_i(clk),
        .reset_i(reset),
        .araddr_i(araddr),
        .arvalid_i(arvalid),
        .arready_o(arready),
        .rdata_o(rdata),
        .rresp_o(rresp),
        .rvalid_o(rvalid),
        .rready_i(rready),
        .rxs_i(rxs),
        .rxs_v_i(rxs_v),
        .rxs_yumi_o(rxs_yumi),
        .rdfo_i(rdfo),
        .isr_i(isr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [N-1:0] pop;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: all sampling on the falling edge.
    int cyc = 0;
    int ar_cyc = 0;
    int yumi_lat = -1;
    int rv_lat = -1;
    int pop_cnt = 0;
    logic [N-1:0] pop_acc = '0;
    logic rv_seen = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pop_acc  = '0;
            pop_cnt  = 0;
            rv_seen  = 1'b0;
            yumi_lat = -1;
            rv_lat   = -1;
        end else begin
            if (arvalid && arready) ar_cyc = cyc;
            if (rxs_yumi != '0) begin
                chk("yumi_without_valid", 32'(rxs_yumi & ~rxs_v), 32'd0);
                pop_acc  = pop_acc | rxs_yumi;
                pop_cnt += $countones(rxs_yumi);
                yumi_lat = cyc - ar_cyc;
            end
            if (rvalid && !rv_seen) begin
                rv_seen = 1'b1;
                rv_lat  = cyc - ar_cyc;
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", 32'(rresp), 32'(e.resp));
                    chk("pop_mask", 32'(pop_acc), 32'(e.pop));
                    chk("pop_count", pop_cnt, (e.pop != '0) ? 1 : 0);
                    chk("rvalid_latency", rv_lat, 2);
                    if (e.pop != '0) chk("yumi_latency", yumi_lat, 1);
                end
                hs_cnt++;
                pop_acc  = '0;
                pop_cnt  = 0;
                rv_seen  = 1'b0;
                yumi_lat = -1;
                rv_lat   = -1;
            end
        end
    end

    task automatic read(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] r, input logic [N-1:0] p,
                        input int stall);
        exp_t e;
        int t;
        int target;
        logic acc;
        e.data = d;
        e.resp = r;
        e.pop  = p;
        exp_q.push_back(e);
        target = hs_cnt + 1;
        @(posedge clk); #1;
        araddr  = a;
        arvalid = 1'b1;
        rready  = (stall == 0);
        t = 0;
        forever begin
            acc = arready;
            @(posedge clk); #1;
            if (acc) break;
            t++;
            if (t > 20) begin
                chk("ar_timeout", 32'd1, 32'd0);
                break;
            end
        end
        arvalid = 1'b0;
        if (stall > 0) begin
            t = 0;
            while (!rvalid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            for (int k = 0; k < stall; k++) begin
                chk("stall_rvalid", 32'(rvalid), 32'd1);
                chk("stall_rdata", rdata, d);
                chk("stall_arready", 32'(arready), 32'd0);
                if (k == 2) rxs[0] = 32'hBADC0FFE;
                @(posedge clk); #1;
            end
            rready = 1'b1;
        end
        t = 0;
        while (hs_cnt < target) begin
            @(posedge clk); #1;
            t++;
            if (t > 50) begin
                chk("r_timeout", 32'd1, 32'd0);
                break;
            end
        end
        chk("arready_after_r", 32'(arready), 32'd1);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_arready", 32'(arready), 32'd1);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rresp", 32'(rresp), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("idle_state",
                {29'd0, arready, rvalid, |rxs_yumi}, 32'd4);
        end

        rxs[1]  = 32'hDEADBEEF;
        rxs_v   = 2'b10;
        rdfo[1] = 32'd5;
        isr[0]  = 32'h0400_0000;
        read(32'h0000_0220, 32'hDEADBEEF, 2'b00, 2'b10, 0);
        read(32'h0000_0120, 32'd0, 2'b10, 2'b00, 0);
        read(32'h0000_021C, 32'd5, 2'b00, 2'b00, 0);
        read(32'h0000_0100, 32'h0400_0000, 2'b00, 2'b00, 0);
        read(32'h0000_0320, 32'd0, 2'b11, 2'b00, 0);
        read(32'h0000_0020, 32'd0, 2'b11, 2'b00, 0);
        read(32'h0000_0104, 32'd0, 2'b00, 2'b00, 0);

        rxs[0] = 32'h1234_5678;
        rxs_v  = 2'b01;
        read(32'h0000_0120, 32'h1234_5678, 2'b00, 2'b01, 7);

        // Reset while the response is pending.
        rxs_v = 2'b00;
        @(posedge clk); #1;
        araddr  = 32'h0000_021C;
        arvalid = 1'b1;
        rready  = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("pre_reset_rvalid", 32'(rvalid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_rvalid", 32'(rvalid), 32'd0);
        chk("mid_reset_arready", 32'(arready), 32'd1);
        reset  = 1'b0;
        rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_rvalid", 32'(rvalid), 32'd0);

        read(32'h0000_021C, 32'd5, 2'b00, 2'b00, 0);
        repeat (2) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
